// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: length header, little-endian words, optional checksum.
// Optional checksum byte after the data is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [31:0]   im_wdata,
    output logic          core_rst_n,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEN_LO = 3'd1;
    localparam logic [2:0] LEN_HI = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] CHK    = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] POST = CHK;
`else
    localparam logic [2:0] POST = DONE;
`endif

    localparam logic [32:0] CAP = 33'(1) << AW;

    logic [2:0]  state;
    logic [7:0]  len_lo;
    logic [15:0] rem;
    logic [1:0]  bidx;
    logic [23:0] part_q;
    logic        last_wr;
    logic [15:0] nwords;
    logic        acc;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  cks;
`endif

    // The last word's write cycle stalls the byte stream so nothing is taken past N words.
    assign byte_ready = (state == LEN_LO) || (state == LEN_HI) || (state == CHK) ||
                        ((state == DATA) && !last_wr);
    assign busy       = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CHK);
    assign done       = (state == DONE);
    assign core_rst_n = (state == DONE);
    assign acc        = byte_valid && byte_ready;
    assign nwords     = {byte_data, len_lo};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            len_lo   <= '0;
            rem      <= '0;
            bidx     <= '0;
            part_q   <= '0;
            last_wr  <= 1'b0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
            err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            cks      <= '0;
`endif
        end else begin
            im_we <= 1'b0;
            if (im_we)
                im_addr <= im_addr + 1'b1;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= LEN_LO;
                        err     <= 1'b0;
                        im_addr <= '0;
                        bidx    <= '0;
                        last_wr <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        cks     <= '0;
`endif
                    end
                end
                LEN_LO: begin
                    if (acc) begin
                        len_lo <= byte_data;
                        state  <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (acc) begin
                        rem <= nwords;
                        if (33'(nwords) > CAP) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end else if (nwords == 16'd0) begin
                            state <= POST;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (last_wr) begin
                        last_wr <= 1'b0;
                        state   <= POST;
                    end else if (acc) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        cks  <= cks ^ byte_data;
`endif
                        bidx <= bidx + 2'd1;
                        // Bytes shift in from the top so byte 0 ends up in bits 7:0.
                        if (bidx == 2'd3) begin
                            im_we    <= 1'b1;
                            im_wdata <= {byte_data, part_q};
                            rem      <= rem - 16'd1;
                            last_wr  <= (rem == 16'd1);
                        end else begin
                            part_q <= {byte_data, part_q[23:8]};
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (acc) begin
                        if (byte_data == cks) begin
                            state <= DONE;
                        end else begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued at stimulus time, popped on im_we.
module tb_imem_loader;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, im_we, core_rst_n, busy, done, err;
    logic [7:0]  im_addr;
    logic [31:0] im_wdata;

    int nchk = 0;
    int npass = 0;
    wr_t sb[$];
    logic [31:0] wq[$];
    logic prev_we = 1'b0;

    imem_loader #(.AW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        if (obs === exp) npass++;
        else $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    endtask

    // Write monitor: pops the scoreboard on every im_we and checks it is a single-cycle pulse.
    always @(negedge clk) begin
        if (rst && im_we) begin
            chk("we_width", prev_we, 1'b0);
            if (sb.size() == 0) begin
                chk("we_unexpected", {im_addr, im_wdata}, 40'h0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("we_addr", im_addr, e.a);
                chk("we_data", im_wdata, e.d);
            end
        end
        prev_we = im_we;
    end

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("rdy_timeout", byte_ready, 1'b1);
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic load(input int gap, input bit mid_start, input bit bad_ck);
        int n;
        logic [7:0] ck;
        logic [31:0] w;
        n  = wq.size();
        ck = 8'h00;
        do_start();
        send_byte(n[7:0], 0);
        send_byte(n[15:8], 0);
        for (int k = 0; k < n; k++) begin
            w = wq[k];
            for (int b = 0; b < 4; b++) begin
                if (b == 3) sb.push_back('{a: k[7:0], d: w});
                ck = ck ^ w[8*b +: 8];
                send_byte(w[8*b +: 8], gap);
                if (mid_start && k == 0 && b == 1) begin
                    start = 1'b1;
                    @(posedge clk);
                    #1 start = 1'b0;
                    chk("midstart_busy", busy, 1'b1);
                end
            end
        end
        if (n > 0) begin
            @(negedge clk);
            chk("last_we", im_we, 1'b1);
            chk("last_rdy", byte_ready, 1'b0);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(ck ^ {7'd0, bad_ck}, 0);
`endif
        @(negedge clk);
        if (bad_ck) begin
            chk("bad_err", err, 1'b1);
            chk("bad_done", done, 1'b0);
            chk("bad_core", core_rst_n, 1'b0);
            chk("bad_busy", busy, 1'b0);
        end else begin
            chk("fin_done", done, 1'b1);
            chk("fin_core", core_rst_n, 1'b1);
            chk("fin_busy", busy, 1'b0);
            chk("fin_err", err, 1'b0);
            chk("fin_rdy", byte_ready, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_vals", {byte_ready, im_we, im_addr, im_wdata, busy, done, err, core_rst_n}, 48'h0);
        @(negedge clk); rst = 1'b1;

        // Two-word program, back-to-back bytes.
        wq = '{32'h0000_0013, 32'h0010_0093};
        load(0, 1'b0, 1'b0);

        // Start from DONE restarts; then an oversized length is rejected.
        do_start();
        chk("restart_core", core_rst_n, 1'b0);
        chk("restart_done", done, 1'b0);
        chk("restart_busy", busy, 1'b1);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        @(negedge clk);
        chk("big_err", err, 1'b1);
        chk("big_busy", busy, 1'b0);
        chk("big_core", core_rst_n, 1'b0);
        chk("big_rdy", byte_ready, 1'b0);
        byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        chk("idle_ignore", {busy, done}, 2'b00);

        // Gapped byte_valid, then start pulsed mid-DATA.
        load(1, 1'b0, 1'b0);
        load(0, 1'b1, 1'b0);

        // Zero-length load.
        wq = {};
        load(0, 1'b0, 1'b0);

        // Reset in the middle of word 0.
        do_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_vals", {byte_ready, im_we, im_addr, im_wdata, busy, done, err, core_rst_n}, 48'h0);
        @(negedge clk); rst = 1'b1;
        wq = '{32'h0000_0013, 32'h0010_0093};
        load(0, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        wq = '{32'h4433_2211};
        load(0, 1'b0, 1'b0);
        load(0, 1'b0, 1'b1);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
